// File: rtl/nlu_pkg.sv
// nlu_pkg: shared types, sizing constants and beat-size encoding for the NLU config loader
package nlu_pkg;
  localparam int MAX_BITS = 1024;
  localparam int CHUNK_W  = 16;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_HI, S_LO, S_DONE} state_e;
  function automatic logic [3:0] sel_enc(input logic [10:0] rem);
    return (rem >= 11'(CHUNK_W)) ? 4'd0 : rem[3:0];
  endfunction
endpackage

// File: rtl/nlu_cfg_loader.sv
// nlu_cfg_loader: splits 32-bit source words into MSB-first 16-bit push beats for a config register
module nlu_cfg_loader
  import nlu_pkg::*;
#(
  parameter int MAX_BITS = 1024,
  parameter int CHUNK_W  = 16
) (
  input  logic        ck,
  input  logic        rst,
  input  logic        start,
  input  logic        target,
  input  logic [10:0] nbits,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  output logic        wready,
  output logic [31:0] dinp,
  output logic        pushnl,
  output logic        pushl,
  output logic [3:0]  sel,
  output logic        busy,
  output logic        done
);
  state_e               state_q, state_d;
  logic [10:0]          rem_q, rem_d, rem_after;
  logic                 tgt_q, tgt_d;
  logic [CHUNK_W-1:0]   lo_q, lo_d, dinp_q, dinp_d;
  logic [3:0]           sel_q, sel_d;
  logic                 pnl_q, pnl_d, pl_q, pl_d;
  assign rem_after = (rem_q > 11'(CHUNK_W)) ? rem_q - 11'(CHUNK_W) : 11'd0;
  assign wready = (state_q == S_WAIT);
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign dinp   = {{(32-CHUNK_W){1'b0}}, dinp_q};
  assign sel    = sel_q;
  assign pushnl = pnl_q;
  assign pushl  = pl_q;
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tgt_d   = tgt_q;
    lo_d    = lo_q;
    dinp_d  = dinp_q;
    sel_d   = sel_q;
    pnl_d   = 1'b0;
    pl_d    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        rem_d   = (nbits > 11'(MAX_BITS)) ? 11'(MAX_BITS) : nbits;
        tgt_d   = target;
        state_d = (nbits == 11'd0) ? S_DONE : S_WAIT;
      end
      S_WAIT: if (wvalid) begin
        dinp_d  = wdata[31 -: CHUNK_W];
        lo_d    = wdata[CHUNK_W-1:0];
        sel_d   = sel_enc(rem_q);
        rem_d   = rem_after;
        pnl_d   = !tgt_q;
        pl_d    = tgt_q;
        state_d = S_HI;
      end
      S_HI: if (rem_q != 11'd0) begin
        dinp_d  = lo_q;
        sel_d   = sel_enc(rem_q);
        rem_d   = rem_after;
        pnl_d   = !tgt_q;
        pl_d    = tgt_q;
        state_d = S_LO;
      end else begin
        // odd chunk count: the held low half is dropped
        state_d = S_DONE;
      end
      S_LO:    state_d = (rem_q != 11'd0) ? S_WAIT : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      tgt_q   <= 1'b0;
      lo_q    <= '0;
      dinp_q  <= '0;
      sel_q   <= '0;
      pnl_q   <= 1'b0;
      pl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tgt_q   <= tgt_d;
      lo_q    <= lo_d;
      dinp_q  <= dinp_d;
      sel_q   <= sel_d;
      pnl_q   <= pnl_d;
      pl_q    <= pl_d;
    end
  end
endmodule

// File: tb/tb_nlu_cfg_loader.sv
// tb_nlu_cfg_loader: directed self-checking bench for the config loader
module tb_nlu_cfg_loader;
  logic        ck = 1'b0;
  logic        rst, start, target, wvalid;
  logic [10:0] nbits;
  logic [31:0] wdata, dinp;
  logic        wready, pushnl, pushl, busy, done;
  logic [3:0]  sel;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, words = 0, dones = 0, both = 0, last_beat = 0, done_cyc = 0;
  logic [31:0] beat_d[$];
  logic [3:0]  beat_s[$];
  logic        beat_l[$];
  logic [15:0] ed[4];
  logic [3:0]  es[4];
  nlu_cfg_loader dut (
    .ck(ck), .rst(rst), .start(start), .target(target), .nbits(nbits),
    .wvalid(wvalid), .wdata(wdata), .wready(wready), .dinp(dinp),
    .pushnl(pushnl), .pushl(pushl), .sel(sel), .busy(busy), .done(done)
  );
  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;
  always @(negedge ck) begin
    if (pushnl || pushl) begin
      beat_d.push_back(dinp);
      beat_s.push_back(sel);
      beat_l.push_back(pushl);
      last_beat = cyc;
    end
    if (wvalid && wready) words++;
    if (done) begin
      dones++;
      done_cyc = cyc;
    end
    if (pushnl && pushl) both++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge ck);
    #1;
  endtask
  task automatic clear();
    beat_d.delete();
    beat_s.delete();
    beat_l.delete();
    words = 0;
    dones = 0;
    both  = 0;
  endtask
  task automatic run_load(input logic t, input logic [10:0] n, input logic [31:0] w0, w1,
                          input int gap, input bit bump, input bit abort);
    int  wi = 0;
    logic gap_bad = 1'b0;
    logic x;
    clear();
    start = 1'b1; target = t; nbits = n;
    tick();
    start = 1'b0;
    for (int g = 0; g < gap; g++) begin
      gap_bad |= !(wready && busy) || pushnl || pushl;
      tick();
    end
    if (gap > 0) chk("gap_wait", {31'd0, gap_bad}, 32'd0);
    wvalid = 1'b1;
    for (int c = 0; c < 400 && dones == 0; c++) begin
      if (abort && pushnl && beat_d.size() == 1) break;
      start  = bump && (c == 3);
      nbits  = bump ? 11'd0 : n;
      target = bump ? !t : t;
      wdata  = (wi == 0) ? w0 : w1;
      x = wvalid && wready;
      tick();
      if (x) wi++;
    end
    start  = 1'b0;
    wvalid = 1'b0;
    if (!abort) chk("done_seen", dones, 1);
  endtask
  task automatic exp_beats(input string tag, input int n, input logic el);
    chk({tag, "_nbeats"}, beat_d.size(), n);
    for (int i = 0; i < n && i < beat_d.size(); i++) begin
      chk($sformatf("%s_dinp%0d", tag, i), beat_d[i], {16'd0, ed[i]});
      chk($sformatf("%s_sel%0d", tag, i), {28'd0, beat_s[i]}, {28'd0, es[i]});
      chk($sformatf("%s_lane%0d", tag, i), {31'd0, beat_l[i]}, {31'd0, el});
    end
    chk({tag, "_both"}, both, 0);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; target = 1'b0; nbits = '0; wvalid = 1'b0; wdata = '0;
    tick();
    tick();
    chk("rst_dinp", dinp, 0);
    chk("rst_sel", {28'd0, sel}, 0);
    chk("rst_strobes", {30'd0, pushnl, pushl}, 0);
    chk("rst_wready", {31'd0, wready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    rst = 1'b0;
    tick();
    run_load(1'b0, 11'd64, 32'hAAAA5555, 32'h12345678, 0, 1'b0, 1'b0);
    ed = '{16'hAAAA, 16'h5555, 16'h1234, 16'h5678}; es = '{4'd0, 4'd0, 4'd0, 4'd0};
    exp_beats("n64", 4, 1'b0);
    chk("n64_words", words, 2);
    chk("n64_done_lat", done_cyc - last_beat, 1);
    tick();
    run_load(1'b1, 11'd20, 32'hABCDF123, 32'h0, 0, 1'b0, 1'b0);
    ed = '{16'hABCD, 16'hF123, 16'h0, 16'h0}; es = '{4'd0, 4'd4, 4'd0, 4'd0};
    exp_beats("n20", 2, 1'b1);
    chk("n20_words", words, 1);
    tick();
    run_load(1'b0, 11'd40, 32'h11112222, 32'h3344FFFF, 0, 1'b0, 1'b0);
    ed = '{16'h1111, 16'h2222, 16'h3344, 16'h0}; es = '{4'd0, 4'd0, 4'd8, 4'd0};
    exp_beats("n40", 3, 1'b0);
    chk("n40_words", words, 2);
    tick();
    run_load(1'b1, 11'd32, 32'hCAFE0BAD, 32'h0, 5, 1'b0, 1'b0);
    ed = '{16'hCAFE, 16'h0BAD, 16'h0, 16'h0}; es = '{4'd0, 4'd0, 4'd0, 4'd0};
    exp_beats("gap32", 2, 1'b1);
    chk("gap32_words", words, 1);
    tick();
    run_load(1'b0, 11'd64, 32'hAAAA5555, 32'h12345678, 0, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_outs", {dinp[15:0], sel, pushnl, pushl, wready, busy, done}, 0);
    repeat (4) tick();
    chk("abort_nodone", dones, 0);
    run_load(1'b0, 11'd16, 32'hBEEF0000, 32'h0, 0, 1'b0, 1'b0);
    ed = '{16'hBEEF, 16'h0, 16'h0, 16'h0}; es = '{4'd0, 4'd0, 4'd0, 4'd0};
    exp_beats("post16", 1, 1'b0);
    chk("post16_words", words, 1);
    tick();
    clear();
    start = 1'b1; nbits = 11'd0; target = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", {31'd0, done}, 1);
    tick();
    chk("zero_done_off", {31'd0, done}, 0);
    chk("zero_beats", beat_d.size(), 0);
    chk("zero_words", words, 0);
    tick();
    run_load(1'b0, 11'd64, 32'hAAAA5555, 32'h12345678, 0, 1'b1, 1'b0);
    ed = '{16'hAAAA, 16'h5555, 16'h1234, 16'h5678}; es = '{4'd0, 4'd0, 4'd0, 4'd0};
    exp_beats("bump", 4, 1'b0);
    chk("bump_dones", dones, 1);
    tick();
    run_load(1'b1, 11'd2047, 32'h0F0F0F0F, 32'h5A5AA5A5, 0, 1'b0, 1'b0);
    chk("sat_beats", beat_d.size(), 64);
    chk("sat_words", words, 32);
    chk("sat_last", beat_d.size() > 0 ? beat_d[beat_d.size()-1] : 32'hDEAD, 32'h0000A5A5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
